ezm_prog_host: RTL and testbench

Host-side counterpart to the ezm_cpu core. It owns the core's clock and reset and feeds its 6-bit instruction port from an on-block program store, indexed by the fetch address. It demultiplexes the core's time-shared 8-bit output bus: PC is on the bus while the core clock is high, the accumulator while it is low. It sits between the chip pins / test harness and the core, so a program can be loaded, run for N steps and inspected.

---
 rtl/ezm_pkg.sv | 29 ++
 rtl/ezm_prog_store.sv | 39 +++
 rtl/ezm_prog_host.sv | 161 ++++++++++++++++
 tb/tb_ezm_prog_host.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ezm_pkg.sv
// Shared definitions for the ezm_cpu host: widths, host FSM states, core opcodes.
package ezm_pkg;

  localparam int unsigned IW = 6;  // core instruction width
  localparam int unsigned DW = 8;  // core data / PC width

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StRunLo,
    StRunHi,
    StDone
  } state_e;

  // Core opcodes. LOAD is any word with the top bit set; the three-bit
  // opcodes occupy instr[5:3] with a register number in instr[2:0].
  localparam logic [IW-1:0] OP_LOAD_MASK = 6'b100000;
  localparam logic [2:0]    OP_BR        = 3'b011;
  localparam logic [2:0]    OP_ST        = 3'b001;
  localparam logic [2:0]    OP_ADD       = 3'b010;
  localparam logic [IW-1:0] OP_NEG       = 6'b000001;
  localparam logic [IW-1:0] OP_NOP       = 6'b000000;

  // Saturating increment used for the unbounded step counter.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == '1) ? v : v + DW'(1);
  endfunction

endpackage

// File: rtl/ezm_prog_store.sv
// Program store for the ezm_cpu host: Depth x IW flops, one write port,
// one asynchronous read port, cleared to NOP by the synchronous reset.
//   clk_i    host clock
//   rst_ni   synchronous active-low reset, clears every entry
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module ezm_prog_store
  import ezm_pkg::*;
#(
  parameter int unsigned Depth = 32,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= OP_NOP;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ezm_prog_host.sv
// Host for the ezm_cpu core: generates the core clock (clk/2) and reset, feeds
// instructions from an on-block program store indexed by the core PC, and
// demultiplexes the core's time-shared output bus (PC while cpu_clk is high,
// accumulator while low).
//   clk_i/rst_ni           host clock, synchronous active-low reset
//   load_valid_i/ready_o   program write handshake; load_addr_i/load_instr_i data
//   run_i                  rising edge starts a run, low requests a stop
//   step_limit_i           core cycles to execute, 0 = unbounded
//   cpu_clk_o/cpu_rst_o    registered core clock and active-high core reset
//   cpu_instr_o            registered instruction to the core
//   cpu_bus_i              core time-multiplexed output
//   pc_q_o/acc_q_o         last captured PC / accumulator
//   busy_o/done_o          run in progress / run finished
module ezm_prog_host
  import ezm_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 32,
  localparam int unsigned AW        = $clog2(PROG_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  input  logic [AW-1:0] load_addr_i,
  input  logic [IW-1:0] load_instr_i,
  input  logic          run_i,
  input  logic [DW-1:0] step_limit_i,
  output logic          cpu_clk_o,
  output logic          cpu_rst_o,
  output logic [IW-1:0] cpu_instr_o,
  input  logic [DW-1:0] cpu_bus_i,
  output logic [DW-1:0] pc_q_o,
  output logic [DW-1:0] acc_q_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic [IW-1:0] cpu_instr_q, cpu_instr_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic          acc_fin_q, acc_fin_d;

  logic          idle_or_done;
  logic          run_edge;
  logic          stop;
  logic          store_we;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

  ezm_prog_store #(
    .Depth (PROG_DEPTH)
  ) u_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (store_we),
    .waddr_i (load_addr_i),
    .wdata_i (load_instr_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign run_edge     = run_i && !run_q;
  assign stop         = ((step_limit_i != '0) && ((cnt_q + DW'(1)) == step_limit_i)) || !run_i;
  assign store_we     = load_valid_i && idle_or_done;
  // CRST fetches the reset vector; otherwise fetch follows the post-edge PC.
  assign rd_addr      = (state_q == StCrst) ? '0 : cpu_bus_i[AW-1:0];

  always_comb begin
    state_d     = state_q;
    cpu_clk_d   = cpu_clk_q;
    cpu_rst_d   = cpu_rst_q;
    cpu_instr_d = cpu_instr_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_fin_d   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // The last instruction's accumulator only reaches the bus once
        // cpu_clk has fallen, so it is picked up in the first DONE cycle.
        if (acc_fin_q) begin
          acc_d = cpu_bus_i;
        end
        if (run_edge) begin
          state_d   = StCrst;
          cpu_rst_d = 1'b1;
          cpu_clk_d = 1'b1;
        end
      end
      StCrst: begin
        if (cpu_clk_q) begin
          cpu_clk_d = 1'b0;
        end else begin
          cpu_rst_d   = 1'b0;
          cnt_d       = '0;
          cpu_instr_d = rd_data;
          state_d     = StRunLo;
        end
      end
      StRunLo: begin
        acc_d     = cpu_bus_i;
        cpu_clk_d = 1'b1;
        state_d   = StRunHi;
      end
      StRunHi: begin
        pc_d        = cpu_bus_i;
        cnt_d       = sat_inc(cnt_q);
        cpu_instr_d = rd_data;
        cpu_clk_d   = 1'b0;
        if (stop) begin
          state_d   = StDone;
          acc_fin_d = 1'b1;
        end else begin
          state_d = StRunLo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cpu_clk_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_instr_q <= OP_NOP;
      pc_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      acc_fin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_instr_q <= cpu_instr_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      run_q       <= run_i;
      acc_fin_q   <= acc_fin_d;
    end
  end

  assign load_ready_o = idle_or_done;
  assign cpu_clk_o    = cpu_clk_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign cpu_instr_o  = cpu_instr_q;
  assign pc_q_o       = pc_q;
  assign acc_q_o      = acc_q;
  assign busy_o       = (state_q == StCrst) || (state_q == StRunLo) || (state_q == StRunHi);
  assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_ezm_prog_host.sv
// Bench for ezm_prog_host with a small instruction-level model of the core.
module tb_ezm_prog_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [4:0] load_addr = '0;
  logic [5:0] load_instr = '0;
  logic       run = 1'b0;
  logic [7:0] step_limit = '0;
  logic       cpu_clk, cpu_rst;
  logic [5:0] cpu_instr;
  logic [7:0] cpu_bus, pc_q, acc_q;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ezm_prog_host dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_addr_i  (load_addr),
    .load_instr_i (load_instr),
    .run_i        (run),
    .step_limit_i (step_limit),
    .cpu_clk_o    (cpu_clk),
    .cpu_rst_o    (cpu_rst),
    .cpu_instr_o  (cpu_instr),
    .cpu_bus_i    (cpu_bus),
    .pc_q_o       (pc_q),
    .acc_q_o      (acc_q),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Instruction-level core: LOAD sign-extends imm5, ST r=acc, ADD acc+=r,
  // NEG acc=~acc, BR taken when r>acc (unsigned) jumps back to the branch
  // after one delay slot. Everything else is a NOP.
  typedef struct packed {
    logic [7:0]      pc;
    logic [7:0]      acc;
    logic [7:0][7:0] r;
    logic            pend;
    logic [7:0]      tgt;
  } core_t;

  function automatic core_t isa_step(input core_t s, input logic [5:0] ins);
    core_t n;
    logic [7:0] rv;
    n = s;
    rv = s.r[ins[2:0]];
    n.pend = 1'b0;
    n.pc = s.pend ? s.tgt : s.pc + 8'd1;
    if (ins[5]) begin
      n.acc = {{3{ins[4]}}, ins[4:0]};
    end else begin
      case (ins[4:3])
        2'b01: n.r[ins[2:0]] = s.acc;
        2'b10: n.acc = s.acc + rv;
        2'b11: if (rv > s.acc) begin
          n.pend = 1'b1;
          n.tgt  = s.pc;
        end
        default: if (ins == 6'b000001) n.acc = ~s.acc;
      endcase
    end
    return n;
  endfunction

  core_t core;
  always @(posedge cpu_clk) begin
    if (cpu_rst) core <= '0;
    else         core <= isa_step(core, cpu_instr);
  end
  assign cpu_bus = cpu_clk ? core.pc : core.acc;

  // Reference: expected program image and an N-step execution from reset.
  logic [5:0] prog_m [32];

  function automatic core_t ref_run(input int n);
    core_t s;
    s = '0;
    for (int i = 0; i < n; i++) s = isa_step(s, prog_m[s.pc[4:0]]);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) prog_m[i] = 6'b0;
  endtask

  task automatic load(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_instr = d;
    @(negedge clk);
    load_valid = 1'b0;
    prog_m[a] = d;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, done=0 required 1", nm);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic start_run(input logic [7:0] lim, input string nm);
    @(negedge clk);
    step_limit = lim; run = 1'b1;
    wait_done(nm);
    run = 1'b0;
  endtask

  typedef struct {
    logic [5:0] p0, p1, p2, p3;
    logic [7:0] lim, epc, eacc;
  } vec_t;

  vec_t tbl [5];
  logic [7:0] pc_seq [6];
  core_t exp_s;
  int lo_seen, guard;

  initial begin
    tbl[0] = '{6'b100101, 6'b001000, 6'b010000, 6'b000001, 8'd4, 8'h04, 8'hF5};
    tbl[1] = '{6'b110000, 6'b000000, 6'b000000, 6'b000000, 8'd1, 8'h01, 8'hF0};
    tbl[2] = '{6'b100010, 6'b001001, 6'b100001, 6'b011001, 8'd6, 8'h04, 8'h01};
    tbl[3] = '{6'b100101, 6'b001000, 6'b010000, 6'b000001, 8'd2, 8'h02, 8'h05};
    tbl[4] = '{6'b100101, 6'b001000, 6'b010000, 6'b000001, 8'd3, 8'h03, 8'h0A};
    pc_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};

    // Reset state.
    do_reset();
    check("rst_flags", {load_ready, busy, done, cpu_rst, cpu_clk}, 5'b10010);
    check("rst_pc", pc_q, 8'h00);
    check("rst_acc", acc_q, 8'h00);
    check("rst_instr", cpu_instr, 6'b0);

    // Directed programs.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load(5'd0, tbl[v].p0); load(5'd1, tbl[v].p1);
      load(5'd2, tbl[v].p2); load(5'd3, tbl[v].p3);
      start_run(tbl[v].lim, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_pc", v), pc_q, tbl[v].epc);
      check($sformatf("vec%0d_acc", v), acc_q, tbl[v].eacc);
      check($sformatf("vec%0d_done", v), {done, busy, cpu_clk}, 3'b100);
    end

    // Branch program: captured PC after each step count.
    for (int k = 1; k <= 6; k++) begin
      do_reset();
      load(5'd0, tbl[2].p0); load(5'd1, tbl[2].p1);
      load(5'd2, tbl[2].p2); load(5'd3, tbl[2].p3);
      start_run(8'(k), "br_seq");
      check($sformatf("br_pc_step%0d", k), pc_q, pc_seq[k-1]);
    end

    // Handshake: writes blocked while busy, accepted in DONE.
    do_reset();
    load(5'd0, 6'b100011);
    @(negedge clk);
    step_limit = 8'd1; run = 1'b1;
    @(negedge clk);
    load_valid = 1'b1; load_addr = 5'd0; load_instr = 6'b100111;
    check("hs_ready_busy", {load_ready, busy}, 2'b01);
    wait_done("hs_run1");
    check("hs_blocked_acc", acc_q, 8'h03);
    check("hs_ready_done", load_ready, 1'b1);
    load_valid = 1'b0; run = 1'b0;
    prog_m[0] = 6'b100111;
    start_run(8'd1, "hs_run2");
    check("hs_written_acc", acc_q, 8'h07);

    // Early stop while unbounded: drop run in the 5th RUN_LO.
    do_reset();
    @(negedge clk);
    step_limit = 8'd0; run = 1'b1;
    lo_seen = 0; guard = 0;
    while (lo_seen < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy && !cpu_rst && !cpu_clk) lo_seen++;
    end
    run = 1'b0;
    check("stop_lo_seen", lo_seen, 5);
    @(negedge clk);
    check("stop_hi", {done, busy, cpu_clk}, 3'b011);
    @(negedge clk);
    check("stop_done", {done, busy, cpu_clk, cpu_rst}, 4'b1000);
    @(negedge clk);
    check("stop_pc", pc_q, 8'h05);

    // Run dropped during CRST: one full core cycle, then DONE.
    do_reset();
    @(negedge clk);
    step_limit = 8'd0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_done("crst_stop");
    check("crst_stop_pc", pc_q, 8'h01);

    // Reset in RUN_HI clears the host and the program store.
    do_reset();
    load(5'd0, 6'b100101);
    @(negedge clk);
    step_limit = 8'd0; run = 1'b1;
    lo_seen = 0; guard = 0;
    while (lo_seen < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy && !cpu_rst && cpu_clk) lo_seen++;
    end
    check("mr_in_run_hi", {busy, cpu_clk}, 2'b11);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_flags", {load_ready, busy, done, cpu_rst, cpu_clk}, 5'b10010);
    check("mr_pc_acc", {pc_q, acc_q}, 16'h0000);
    prog_m[0] = 6'b0;
    start_run(8'd1, "mr_rerun");
    check("mr_store_cleared", {pc_q, acc_q}, 16'h0100);

    // Randomized programs against the reference model.
    for (int t = 0; t < 20; t++) begin
      int lim;
      do_reset();
      for (int a = 0; a < 32; a++) load(5'(a), 6'($urandom_range(63)));
      lim = $urandom_range(40, 1);
      start_run(8'(lim), "rnd");
      exp_s = ref_run(lim);
      check($sformatf("rnd%0d_pc", t), pc_q, exp_s.pc);
      check($sformatf("rnd%0d_acc", t), acc_q, exp_s.acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
